// File: rtl/db9_pkg.sv
// Shared definitions for the DB9 Mega Drive pad scanner: joystick bit map,
// pad bus bit positions, scan states and the select phases that carry data.
package db9_pkg;

    localparam int JB_RIGHT = 0;
    localparam int JB_LEFT  = 1;
    localparam int JB_DOWN  = 2;
    localparam int JB_UP    = 3;
    localparam int JB_B     = 4;
    localparam int JB_C     = 5;
    localparam int JB_A     = 6;
    localparam int JB_START = 7;
    localparam int JB_MODE  = 8;
    localparam int JB_X     = 9;
    localparam int JB_Y     = 10;
    localparam int JB_Z     = 11;

    localparam int BUS_UP    = 0;
    localparam int BUS_DOWN  = 1;
    localparam int BUS_LEFT  = 2;
    localparam int BUS_RIGHT = 3;
    localparam int BUS_B     = 4;
    localparam int BUS_C     = 5;

    typedef enum logic [1:0] {
        IDLE1 = 2'd0,
        SCAN1 = 2'd1,
        IDLE2 = 2'd2,
        SCAN2 = 2'd3
    } scan_state_t;

    localparam logic [2:0] P_BASE  = 3'd0;
    localparam logic [2:0] P_ABS   = 3'd1;
    localparam logic [2:0] P_SIXID = 3'd5;
    localparam logic [2:0] P_EXT   = 3'd6;
    localparam logic [2:0] P_LAST  = 3'd7;

    typedef struct packed {
        logic [15:0] word;
        logic        present;
        logic        six;
    } pad_result_t;

    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/db9_pad_decode.sv
// Turns the raw active-low samples of one pad scan into an active-high
// joystick word plus presence and six-button flags.
module db9_pad_decode
    import db9_pkg::*;
(
    input  logic [5:0]  smp_base,
    input  logic [3:0]  smp_abs,
    input  logic [3:0]  smp_sixid,
    input  logic [3:0]  smp_ext,
    output pad_result_t result
);

    // smp_abs holds bus bits [5:2]: Left, Right, A, Start
    always_comb begin
        result         = '0;
        result.present = ~smp_abs[0] & ~smp_abs[1];
        result.six     = result.present & (smp_sixid == 4'b0000);

        if (result.present) begin
            result.word[JB_RIGHT] = ~smp_base[BUS_RIGHT];
            result.word[JB_LEFT]  = ~smp_base[BUS_LEFT];
            result.word[JB_DOWN]  = ~smp_base[BUS_DOWN];
            result.word[JB_UP]    = ~smp_base[BUS_UP];
            result.word[JB_B]     = ~smp_base[BUS_B];
            result.word[JB_C]     = ~smp_base[BUS_C];
            result.word[JB_A]     = ~smp_abs[2];
            result.word[JB_START] = ~smp_abs[3];
        end

        if (result.six) begin
            result.word[JB_Z]    = ~smp_ext[0];
            result.word[JB_Y]    = ~smp_ext[1];
            result.word[JB_X]    = ~smp_ext[2];
            result.word[JB_MODE] = ~smp_ext[3];
        end
    end

endmodule

// File: rtl/db9_md_pad_scanner.sv
// Scans two Mega Drive pads through a shared DB9 splitter, alternating ports,
// and commits each pad's word atomically at the end of its scan.
module db9_md_pad_scanner
    import db9_pkg::*;
#(
    parameter int PHASE_CYCLES = 64,
    parameter int IDLE_CYCLES  = 20000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  joy_in,
    output logic        joy_mdsel,
    output logic        joy_split,
    output logic [15:0] joystick1,
    output logic [15:0] joystick2,
    output logic [1:0]  pad_present,
    output logic [1:0]  pad_six,
    output logic [1:0]  upd
);

    localparam int CNT_W = cnt_width(IDLE_CYCLES, PHASE_CYCLES);
    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(PHASE_CYCLES - 1);

    scan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       phase_q, phase_d;
    logic [5:0]       joy_s1_q, joy_s1_d;
    logic [5:0]       joy_s2_q, joy_s2_d;
    logic [5:0]       smp_base_q, smp_base_d;
    logic [3:0]       smp_abs_q, smp_abs_d;
    logic [3:0]       smp_sixid_q, smp_sixid_d;
    logic [3:0]       smp_ext_q, smp_ext_d;
    logic [15:0]      joystick1_q, joystick1_d;
    logic [15:0]      joystick2_q, joystick2_d;
    logic [1:0]       present_q, present_d;
    logic [1:0]       six_q, six_d;
    logic [1:0]       upd_q, upd_d;
    logic             scanning;
    pad_result_t      dec;

    db9_pad_decode u_decode (
        .smp_base  (smp_base_q),
        .smp_abs   (smp_abs_q),
        .smp_sixid (smp_sixid_q),
        .smp_ext   (smp_ext_q),
        .result    (dec)
    );

    // The counter is only ever cleared by a state or phase transition, so the
    // select waveform cannot drift relative to the sampling points.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        phase_d     = phase_q;
        joy_s1_d    = joy_in;
        joy_s2_d    = joy_s1_q;
        smp_base_d  = smp_base_q;
        smp_abs_d   = smp_abs_q;
        smp_sixid_d = smp_sixid_q;
        smp_ext_d   = smp_ext_q;
        joystick1_d = joystick1_q;
        joystick2_d = joystick2_q;
        present_d   = present_q;
        six_d       = six_q;
        upd_d       = 2'b00;

        unique case (state_q)
            IDLE1, IDLE2: begin
                if (cnt_q == IDLE_LAST) begin
                    state_d = (state_q == IDLE1) ? SCAN1 : SCAN2;
                    cnt_d   = '0;
                    phase_d = P_BASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SCAN1, SCAN2: begin
                if (cnt_q == PHASE_LAST) begin
                    cnt_d   = '0;
                    phase_d = phase_q + 3'd1;
                    case (phase_q)
                        P_BASE:  smp_base_d  = joy_s2_q;
                        P_ABS:   smp_abs_d   = joy_s2_q[5:2];
                        P_SIXID: smp_sixid_d = joy_s2_q[3:0];
                        P_EXT:   smp_ext_d   = joy_s2_q[3:0];
                        P_LAST: begin
                            if (state_q == SCAN1) begin
                                joystick1_d  = dec.word;
                                present_d[0] = dec.present;
                                six_d[0]     = dec.six;
                                upd_d[0]     = 1'b1;
                                state_d      = IDLE2;
                            end else begin
                                joystick2_d  = dec.word;
                                present_d[1] = dec.present;
                                six_d[1]     = dec.six;
                                upd_d[1]     = 1'b1;
                                state_d      = IDLE1;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE1;
                cnt_d   = '0;
            end
        endcase
    end

    // Reset also wipes the sample registers so an interrupted scan is never reused.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE1;
            cnt_q       <= '0;
            phase_q     <= P_BASE;
            joy_s1_q    <= 6'h3F;
            joy_s2_q    <= 6'h3F;
            smp_base_q  <= 6'h3F;
            smp_abs_q   <= 4'hF;
            smp_sixid_q <= 4'hF;
            smp_ext_q   <= 4'hF;
            joystick1_q <= '0;
            joystick2_q <= '0;
            present_q   <= 2'b00;
            six_q       <= 2'b00;
            upd_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            joy_s1_q    <= joy_s1_d;
            joy_s2_q    <= joy_s2_d;
            smp_base_q  <= smp_base_d;
            smp_abs_q   <= smp_abs_d;
            smp_sixid_q <= smp_sixid_d;
            smp_ext_q   <= smp_ext_d;
            joystick1_q <= joystick1_d;
            joystick2_q <= joystick2_d;
            present_q   <= present_d;
            six_q       <= six_d;
            upd_q       <= upd_d;
        end
    end

    assign scanning    = (state_q == SCAN1) || (state_q == SCAN2);
    assign joy_mdsel   = scanning ? ~phase_q[0] : 1'b1;
    assign joy_split   = (state_q == IDLE2) || (state_q == SCAN2);
    assign joystick1   = joystick1_q;
    assign joystick2   = joystick2_q;
    assign pad_present = present_q;
    assign pad_six     = six_q;
    assign upd         = upd_q;

endmodule
